// File: rtl/vlsu_txn_sequencer.sv
// vlsu_txn_sequencer
//
// Turns one vector load/store request into a stream of memory transactions.
// A request describes ngrp groups of nseg segments, each segment segb bytes
// long. Segment start addresses follow one of four address patterns selected
// by req_mode_i:
//   INCR  : segments packed back to back
//   STRD  : every segment one stride after the previous one
//   ROW2D : segments packed inside a group, groups one stride apart
//   CLN2D : segments one stride apart inside a group, groups packed
// Each segment is cut into transactions that never cross a MAX_TXN_B
// boundary. Transactions come out in order: within a segment, then segment
// by segment, then group by group.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o  request handshake, ready only while idle
//   req_mode_i                 one-hot mode {CLN2D, ROW2D, STRD, INCR}
//   req_base_i, req_stride_i   start address, signed byte stride
//   req_nseg_i, req_ngrp_i     segments per group, number of groups
//   req_segb_i                 bytes per segment
//   txn_valid_o / txn_ready_i  transaction handshake
//   txn_addr_o, txn_len_o      transaction byte address and byte count
//   txn_final_o                marks the last transaction of the request
//   done_o                     one-cycle pulse when a request completes
//   err_o                      one-cycle pulse for a rejected (illegal) mode
//
// Build option
//   VLSU_MODE_CHECK_EN : when defined, a mode that is not exactly one-hot is
//   accepted, produces no transaction and pulses err_o instead of done_o.
//   When undefined, err_o stays 0 and the lowest set mode bit wins, with an
//   all-zero mode behaving as INCR.
//
// FSM states
//   state | meaning
//   IDLE  | waiting for a request, req_ready_o high
//   ISSUE | presenting transactions of the accepted request

module vlsu_txn_sequencer #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned SEGB_W    = 16,
  parameter int unsigned MAX_TXN_B = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [3:0]                   req_mode_i,
  input  logic [ADDR_W-1:0]            req_base_i,
  input  logic [ADDR_W-1:0]            req_stride_i,
  input  logic [CNT_W-1:0]             req_nseg_i,
  input  logic [CNT_W-1:0]             req_ngrp_i,
  input  logic [SEGB_W-1:0]            req_segb_i,
  output logic                         txn_valid_o,
  input  logic                         txn_ready_i,
  output logic [ADDR_W-1:0]            txn_addr_o,
  output logic [$clog2(MAX_TXN_B):0]   txn_len_o,
  output logic                         txn_final_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int unsigned LEN_W = $clog2(MAX_TXN_B) + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(MAX_TXN_B - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // Length of the transaction starting at addr with rem bytes left in the
  // segment: stop at the next MAX_TXN_B boundary. For aligned addresses the
  // room is a full MAX_TXN_B, so the same function serves every transaction.
  function automatic logic [LEN_W-1:0] txn_len_f(input logic [ADDR_W-1:0] addr,
                                                 input logic [SEGB_W-1:0] rem);
    logic [31:0] room;
    logic [31:0] rem32;
    room  = 32'(MAX_TXN_B) - 32'(addr & OFF_MASK);
    rem32 = 32'(rem);
    return (rem32 < room) ? LEN_W'(rem32) : LEN_W'(room);
  endfunction

  state_e               state_q,     state_d;
  logic                 txn_valid_q, txn_valid_d;
  logic [ADDR_W-1:0]    txn_addr_q,  txn_addr_d;
  logic [LEN_W-1:0]     txn_len_q,   txn_len_d;
  logic                 txn_final_q, txn_final_d;
  logic                 done_q,      done_d;
  logic                 err_q,       err_d;

  // Latched request shape. Steps are resolved from the mode at acceptance so
  // the issue path only ever adds.
  logic [ADDR_W-1:0]    seg_step_q,  seg_step_d;
  logic [ADDR_W-1:0]    grp_step_q,  grp_step_d;
  logic                 linear_q,    linear_d;
  logic [SEGB_W-1:0]    segb_q,      segb_d;
  logic [CNT_W-1:0]     nseg_q,      nseg_d;

  // Running pointers and down counters (counts left after the current item).
  logic [ADDR_W-1:0]    grp_ptr_q,   grp_ptr_d;
  logic [ADDR_W-1:0]    seg_ptr_q,   seg_ptr_d;
  logic [CNT_W-1:0]     grp_left_q,  grp_left_d;
  logic [CNT_W-1:0]     seg_left_q,  seg_left_d;
  logic [SEGB_W-1:0]    rem_b_q,     rem_b_d;

  logic                 m_incr, m_strd, m_row, m_cln;
  logic                 mode_bad;
  logic                 req_empty;
  logic [ADDR_W-1:0]    segb_ext;
  logic [ADDR_W-1:0]    next_addr;
  logic [SEGB_W-1:0]    next_rem;
  logic [LEN_W-1:0]     next_len;

  // Lowest set bit wins; an all-zero mode falls back to INCR.
  always_comb begin
    m_incr = req_mode_i[0] || (req_mode_i == 4'b0000);
    m_strd = (req_mode_i[1:0] == 2'b10);
    m_row  = (req_mode_i[2:0] == 3'b100);
    m_cln  = (req_mode_i == 4'b1000);
  end

`ifdef VLSU_MODE_CHECK_EN
  assign mode_bad = (req_mode_i == 4'b0000) ||
                    ((req_mode_i & (req_mode_i - 4'd1)) != 4'b0000);
`else
  assign mode_bad = 1'b0;
`endif

  assign req_empty = (req_nseg_i == '0) || (req_ngrp_i == '0) || (req_segb_i == '0);
  assign segb_ext  = ADDR_W'(req_segb_i);

  always_comb begin
    state_d     = state_q;
    txn_valid_d = txn_valid_q;
    txn_addr_d  = txn_addr_q;
    txn_len_d   = txn_len_q;
    txn_final_d = txn_final_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    seg_step_d  = seg_step_q;
    grp_step_d  = grp_step_q;
    linear_d    = linear_q;
    segb_d      = segb_q;
    nseg_d      = nseg_q;
    grp_ptr_d   = grp_ptr_q;
    seg_ptr_d   = seg_ptr_q;
    grp_left_d  = grp_left_q;
    seg_left_d  = seg_left_q;
    rem_b_d     = rem_b_q;
    next_addr   = '0;
    next_rem    = '0;
    next_len    = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          segb_d     = req_segb_i;
          nseg_d     = req_nseg_i;
          linear_d   = m_incr || m_strd;
          seg_step_d = (m_strd || m_cln) ? req_stride_i : segb_ext;
          grp_step_d = m_row ? req_stride_i : segb_ext;
          if (mode_bad) begin
            err_d = 1'b1;
          end else if (req_empty) begin
            done_d = 1'b1;
          end else begin
            next_len    = txn_len_f(req_base_i, req_segb_i);
            state_d     = ISSUE;
            txn_valid_d = 1'b1;
            txn_addr_d  = req_base_i;
            txn_len_d   = next_len;
            grp_ptr_d   = req_base_i;
            seg_ptr_d   = req_base_i;
            seg_left_d  = req_nseg_i - CNT_W'(1);
            grp_left_d  = req_ngrp_i - CNT_W'(1);
            rem_b_d     = req_segb_i - SEGB_W'(next_len);
            txn_final_d = (seg_left_d == '0) && (grp_left_d == '0) && (rem_b_d == '0);
          end
        end
      end

      ISSUE: begin
        if (txn_ready_i) begin
          if (txn_final_q) begin
            state_d     = IDLE;
            txn_valid_d = 1'b0;
            txn_final_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            if (rem_b_q != '0) begin
              // continue the current segment from the boundary just reached
              next_addr = txn_addr_q + ADDR_W'(txn_len_q);
              next_rem  = rem_b_q;
            end else if (seg_left_q != '0) begin
              seg_left_d = seg_left_q - CNT_W'(1);
              next_addr  = seg_ptr_q + seg_step_q;
              seg_ptr_d  = next_addr;
              next_rem   = segb_q;
            end else begin
              // INCR/STRD keep walking the segment pointer across groups;
              // the 2D modes restart from the next group origin.
              grp_left_d = grp_left_q - CNT_W'(1);
              seg_left_d = nseg_q - CNT_W'(1);
              grp_ptr_d  = grp_ptr_q + grp_step_q;
              next_addr  = linear_q ? (seg_ptr_q + seg_step_q) : grp_ptr_d;
              seg_ptr_d  = next_addr;
              next_rem   = segb_q;
            end
            next_len    = txn_len_f(next_addr, next_rem);
            txn_addr_d  = next_addr;
            txn_len_d   = next_len;
            rem_b_d     = next_rem - SEGB_W'(next_len);
            txn_final_d = (seg_left_d == '0) && (grp_left_d == '0) && (rem_b_d == '0);
          end
        end
      end

      default: begin
        state_d     = IDLE;
        txn_valid_d = 1'b0;
        txn_final_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      txn_valid_q <= 1'b0;
      txn_addr_q  <= '0;
      txn_len_q   <= '0;
      txn_final_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      seg_step_q  <= '0;
      grp_step_q  <= '0;
      linear_q    <= 1'b0;
      segb_q      <= '0;
      nseg_q      <= '0;
      grp_ptr_q   <= '0;
      seg_ptr_q   <= '0;
      grp_left_q  <= '0;
      seg_left_q  <= '0;
      rem_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      txn_valid_q <= txn_valid_d;
      txn_addr_q  <= txn_addr_d;
      txn_len_q   <= txn_len_d;
      txn_final_q <= txn_final_d;
      done_q      <= done_d;
      err_q       <= err_d;
      seg_step_q  <= seg_step_d;
      grp_step_q  <= grp_step_d;
      linear_q    <= linear_d;
      segb_q      <= segb_d;
      nseg_q      <= nseg_d;
      grp_ptr_q   <= grp_ptr_d;
      seg_ptr_q   <= seg_ptr_d;
      grp_left_q  <= grp_left_d;
      seg_left_q  <= seg_left_d;
      rem_b_q     <= rem_b_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign txn_valid_o = txn_valid_q;
  assign txn_addr_o  = txn_addr_q;
  assign txn_len_o   = txn_len_q;
  assign txn_final_o = txn_final_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: doc/vlsu_txn_sequencer.md
VLSU_TXN_SEQUENCER -- requirements
Module: vlsu_txn_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address and stride width.
REQ-002 SHALL have parameter CNT_W, default 8, width of segment-count and group-count fields.
REQ-003 SHALL have parameter SEGB_W, default 16, width of segment byte length.
REQ-004 SHALL have parameter MAX_TXN_B, default 64, max bytes per transaction; power of two, at least 1.
REQ-005 SHALL have port clk_i, in, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_ni, in, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid_i / req_ready_o, in/out, 1 each, request handshake.
REQ-008 SHALL have port req_mode_i, in, 4, one-hot mode: bit0 INCR, bit1 STRD, bit2 ROW2D, bit3 CLN2D.
REQ-009 SHALL have port req_base_i, in, ADDR_W, start address.
REQ-010 SHALL have port req_stride_i, in, ADDR_W, byte stride (two's complement).
REQ-011 SHALL have port req_nseg_i / req_ngrp_i, in, CNT_W each, segments per group / group count.
REQ-012 SHALL have port req_segb_i, in, SEGB_W, bytes per segment.
REQ-013 SHALL have port txn_valid_o / txn_ready_i, out/in, 1 each, transaction handshake.
REQ-014 SHALL have port txn_addr_o, out, ADDR_W, transaction byte address.
REQ-015 SHALL have port txn_len_o, out, $clog2(MAX_TXN_B)+1, transaction byte count, 1..MAX_TXN_B.
REQ-016 SHALL have port txn_final_o, out, 1, last transaction of request (last group, last segment, last txn).
REQ-017 SHALL have port done_o, out, 1, one-cycle pulse when a request completes.
REQ-018 SHALL have port err_o, out, 1, one-cycle illegal-mode pulse (see REQ-034).

Function
REQ-019 FSM SHALL have states IDLE, ISSUE; req_ready_o=1 only in IDLE.
REQ-020 On request handshake SHALL latch all fields; if nseg, ngrp or segb is 0, SHALL stay IDLE and pulse done_o next cycle, issuing no txn.
REQ-021 Otherwise SHALL enter ISSUE; txn_valid_o asserts the cycle after acceptance (latency 1).
REQ-022 Segment start address SHALL be, g = group index, s = segment index: INCR base+(g*nseg+s)*segb; STRD base+(g*nseg+s)*stride; ROW2D base+g*stride+s*segb; CLN2D base+g*segb+s*stride.
REQ-023 Addresses SHALL use running group/segment pointer registers updated by addition only (no multiplier); sums wrap modulo 2^ADDR_W.
REQ-024 Each segment SHALL split into txns: first len = min(remaining, MAX_TXN_B - (addr mod MAX_TXN_B)); later txns MAX_TXN_B-aligned, len = min(remaining, MAX_TXN_B); no txn crosses a MAX_TXN_B boundary.
REQ-025 Order SHALL be txns within segment, segments within group, groups ascending.
REQ-026 txn outputs SHALL be registered and held stable while txn_valid_o=1 and txn_ready_i=0.
REQ-027 On each txn handshake the next txn SHALL be presented the following cycle (one txn per cycle sustained).
REQ-028 txn_final_o SHALL be 1 only with the final txn; on its handshake FSM returns to IDLE, done_o pulses the same edge, and req_ready_o is 1 the next cycle.
REQ-029 A new request SHALL NOT be accepted in the cycle the final txn handshakes.
REQ-030 Remaining-group, remaining-segment and txn counters SHALL be down/up counters compared against 0/txn total to derive last-txn, last-seg, last-grp.

Reset
REQ-031 On rst_ni low SHALL asynchronously force IDLE, req_ready_o=1, txn_valid_o=0, txn_final_o=0, done_o=0, err_o=0, txn_addr_o=0, txn_len_o=0, all counters and pointers 0.
REQ-032 Reset asserted mid-request SHALL discard the request with no done_o.

Configuration
REQ-033 Macro VLSU_MODE_CHECK_EN SHALL select mode-legality handling.
REQ-034 With it defined, a request whose req_mode_i is not exactly one-hot SHALL be accepted, issue no txn, pulse err_o next cycle, no done_o.
REQ-035 Without it, err_o SHALL be tied 0 and mode SHALL be priority-decoded, lowest set bit wins; mode 0 treated as INCR.

Verification
REQ-036 INCR, base 0x10, nseg 2, ngrp 1, segb 100, MAX 64, ready=1 -> txns (0x10,48),(0x40,52),(0x74,12),(0x80,64),(0xC0,24)? no: seg1 starts 0x74 -> (0x74,12),(0x80,64),(0xC0,24); final on last, done_o pulse.
REQ-037 ROW2D, base 0x1000, stride 0x200, nseg 2, ngrp 2, segb 16 -> addrs 0x1000,0x1010,0x1200,0x1210, each len 16.
REQ-038 CLN2D, base 0, stride 0x100, nseg 3, ngrp 2, segb 8 -> addrs 0x0,0x100,0x200,0x8,0x108,0x208.
REQ-039 STRD with txn_ready_i toggling every cycle -> outputs stable while stalled, same sequence as ready=1.
REQ-040 Mode 4'b0011 -> with VLSU_MODE_CHECK_EN: err_o pulse, no txn; without: INCR behaviour, err_o=0.
REQ-041 Reset asserted after 2nd txn of 5 -> txn_valid_o=0 immediately, req_ready_o=1, no done_o.
